// File: rtl/spi_slave_tx_fifo_if.sv
// Bundle of the SPI pins and the TX push port of spi_slave_tx_fifo.
// The slave modport is the peripheral side; master is the controller/producer side.
interface spi_slave_tx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     spi_sck;
  logic                     spi_csn;
  logic                     spi_sdo;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [$clog2(DEPTH):0]   level;
  logic                     underrun;
  logic                     active;

  modport slave (
    input  spi_sck, spi_csn, tx_data, tx_valid,
    output spi_sdo, tx_ready, level, underrun, active
  );

  modport master (
    output spi_sck, spi_csn, tx_data, tx_valid,
    input  spi_sdo, tx_ready, level, underrun, active
  );
endinterface

// File: rtl/spi_slave_tx_fifo.sv
// Oversampled SPI peripheral transmitter: SCK/CSN are synchronised into clk and words
// from a small TX FIFO are shifted out on SDO; an empty FIFO sends IDLE_WORD.
module spi_slave_tx_fifo #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               CPOL      = 0,
  parameter int               CPHA      = 0,
  parameter int               LSB_FIRST = 0,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input logic               clk,
  input logic               rst_n,
  spi_slave_tx_fifo_if.slave bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(WIDTH);
  localparam logic           IDLE_LVL = (CPOL != 0);
  localparam logic           PHA      = (CPHA != 0);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic             sck_p0, sck_p1, sck_p2;
  logic             csn_p0, csn_p1, csn_p2;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             need_load;
  logic             underrun_r;

  logic             csn_fall, csn_rise, sck_en, lead, trail, sample, launch;
  logic             empty, full, load, push, pop;
  logic [WIDTH-1:0] load_word;

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    if (LSB_FIRST != 0) shift_out = {1'b0, w[WIDTH-1:1]};
    else                shift_out = {w[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    if (LSB_FIRST != 0) out_bit = w[0];
    else                out_bit = w[WIDTH-1];
  endfunction

  // Edge detection on synced values; a csn edge in the same clk suppresses any sck edge.
  always_comb begin
    csn_fall  = csn_p2 & ~csn_p1;
    csn_rise  = ~csn_p2 & csn_p1;
    sck_en    = ~csn_p2 & ~csn_p1;
    lead      = sck_en && (sck_p2 == IDLE_LVL) && (sck_p1 != IDLE_LVL);
    trail     = sck_en && (sck_p2 != IDLE_LVL) && (sck_p1 == IDLE_LVL);
    sample    = PHA ? trail : lead;
    launch    = PHA ? lead  : trail;
    empty     = (count == '0);
    full      = (count == FULL_LVL);
    load      = (csn_fall && !PHA) || (launch && need_load);
    pop       = load && !empty;
    push      = bus.tx_valid && !full;
    load_word = empty ? IDLE_WORD : mem[rd_ptr];
  end

  // Stage p0/p1: synchroniser; stage p2: previous synced value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_p0 <= IDLE_LVL;
      sck_p1 <= IDLE_LVL;
      sck_p2 <= IDLE_LVL;
      csn_p0 <= 1'b1;
      csn_p1 <= 1'b1;
      csn_p2 <= 1'b1;
    end else begin
      sck_p0 <= bus.spi_sck;
      sck_p1 <= sck_p0;
      sck_p2 <= sck_p1;
      csn_p0 <= bus.spi_csn;
      csn_p1 <= csn_p0;
      csn_p2 <= csn_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Shift engine: an aborted word is simply dropped, never pushed back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      need_load  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= load && empty;
      if (csn_fall) begin
        bit_cnt   <= '0;
        need_load <= PHA;
        shreg     <= PHA ? '0 : load_word;
      end else if (csn_rise) begin
        bit_cnt   <= '0;
        need_load <= 1'b0;
      end else begin
        if (sample) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt   <= '0;
            need_load <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (launch) begin
          if (need_load) begin
            shreg     <= load_word;
            need_load <= 1'b0;
          end else begin
            shreg <= shift_out(shreg);
          end
        end
      end
    end
  end

  assign bus.spi_sdo  = ~csn_p2 & out_bit(shreg);
  assign bus.tx_ready = ~full;
  assign bus.level    = count;
  assign bus.underrun = underrun_r;
  assign bus.active   = ~csn_p2;

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Directed bench: dut0 is mode 0 / 8-bit / MSB-first with IDLE_WORD 0xFF,
// dut1 is CPOL=1 CPHA=1 / 16-bit / LSB-first.
module tb_spi_slave_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ucnt0 = 0;
  int   ucnt1 = 0;

  always #5 clk = ~clk;

  spi_slave_tx_fifo_if #(.WIDTH(8),  .DEPTH(4)) sif0 ();
  spi_slave_tx_fifo_if #(.WIDTH(16), .DEPTH(4)) sif1 ();

  spi_slave_tx_fifo #(
    .WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .IDLE_WORD(8'hFF)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif0.slave)
  );

  spi_slave_tx_fifo #(
    .WIDTH(16), .DEPTH(4), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .IDLE_WORD(16'h0000)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif1.slave)
  );

  always @(negedge clk) begin
    if (sif0.underrun === 1'b1) ucnt0 <= ucnt0 + 1;
    if (sif1.underrun === 1'b1) ucnt1 <= ucnt1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d);
    sif0.tx_data  = d;
    sif0.tx_valid = 1'b1;
    tick(1);
    sif0.tx_valid = 1'b0;
  endtask

  task automatic sel0();
    sif0.spi_csn = 1'b0;
    tick(4);
  endtask

  // Mode-0 controller: sample SDO just before each rising edge; the final falling
  // edge is issued after csn has been released so no further load is triggered.
  task automatic xfer_bits(input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      rx = {rx[62:0], sif0.spi_sdo};
      sif0.spi_sck = 1'b1;
      tick(4);
      if (i != n - 1) begin
        sif0.spi_sck = 1'b0;
        tick(4);
      end
    end
    sif0.spi_csn = 1'b1;
    tick(4);
    sif0.spi_sck = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    checks++; if (sif0.level !== 3'd0) begin errors++; $display("FAIL reset_level0: got %0d expected 0", sif0.level); end
    checks++; if (sif0.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", sif0.tx_ready); end
    checks++; if (sif0.spi_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo0: got %b expected 0", sif0.spi_sdo); end
    checks++; if (sif0.active !== 1'b0) begin errors++; $display("FAIL reset_active0: got %b expected 0", sif0.active); end
    checks++; if (sif0.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun0: got %b expected 0", sif0.underrun); end
    checks++; if (sif1.level !== 3'd0) begin errors++; $display("FAIL reset_level1: got %0d expected 0", sif1.level); end
    checks++; if (sif1.spi_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo1: got %b expected 0", sif1.spi_sdo); end
  endtask

  task automatic test_two_words();
    logic [63:0] rx;
    int base;
    base = ucnt0;
    push0(8'hA5);
    push0(8'h3C);
    checks++; if (sif0.level !== 3'd2) begin errors++; $display("FAIL tw_level2: got %0d expected 2", sif0.level); end
    sel0();
    checks++; if (sif0.level !== 3'd1) begin errors++; $display("FAIL tw_level1: got %0d expected 1", sif0.level); end
    checks++; if (sif0.active !== 1'b1) begin errors++; $display("FAIL tw_active: got %b expected 1", sif0.active); end
    xfer_bits(16, rx);
    checks++; if (rx[15:0] !== 16'hA53C) begin errors++; $display("FAIL tw_data: got %h expected a53c", rx[15:0]); end
    checks++; if (sif0.level !== 3'd0) begin errors++; $display("FAIL tw_level0: got %0d expected 0", sif0.level); end
    checks++; if (sif0.active !== 1'b0) begin errors++; $display("FAIL tw_inactive: got %b expected 0", sif0.active); end
    checks++; if (ucnt0 - base !== 0) begin errors++; $display("FAIL tw_underrun: got %0d pulses expected 0", ucnt0 - base); end
  endtask

  task automatic test_underrun();
    logic [63:0] rx;
    int base;
    base = ucnt0;
    sif0.spi_csn = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick(1);
      checks++;
      if (sif0.underrun !== (j == 3)) begin
        errors++; $display("FAIL ur_timing: clk %0d got %b expected %b", j, sif0.underrun, (j == 3));
      end
    end
    xfer_bits(8, rx);
    checks++; if (rx[7:0] !== 8'hFF) begin errors++; $display("FAIL ur_data: got %h expected ff", rx[7:0]); end
    checks++; if (ucnt0 - base !== 1) begin errors++; $display("FAIL ur_count: got %0d pulses expected 1", ucnt0 - base); end
  endtask

  task automatic test_abort();
    logic [63:0] rx;
    push0(8'hF0);
    push0(8'h81);
    sel0();
    xfer_bits(3, rx);
    checks++; if (rx[2:0] !== 3'b111) begin errors++; $display("FAIL ab_partial: got %b expected 111", rx[2:0]); end
    sel0();
    xfer_bits(8, rx);
    checks++; if (rx[7:0] !== 8'h81) begin errors++; $display("FAIL ab_data: got %h expected 81", rx[7:0]); end
    checks++; if (sif0.level !== 3'd0) begin errors++; $display("FAIL ab_level: got %0d expected 0", sif0.level); end
  endtask

  task automatic test_full();
    logic [63:0] rx;
    logic [7:0]  w [5];
    int base;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    base = ucnt0;
    sif0.tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sif0.tx_data = w[i];
      tick(1);
    end
    sif0.tx_data = w[4];
    checks++; if (sif0.tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", sif0.tx_ready); end
    checks++; if (sif0.level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", sif0.level); end
    tick(2);
    checks++; if (sif0.level !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d expected 4", sif0.level); end
    sif0.spi_csn = 1'b0;
    tick(3);
    checks++; if (sif0.level !== 3'd3 || sif0.tx_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop: got level %0d ready %b expected 3 1", sif0.level, sif0.tx_ready);
    end
    tick(1);
    sif0.tx_valid = 1'b0;
    checks++; if (sif0.level !== 3'd4 || sif0.tx_ready !== 1'b0) begin
      errors++; $display("FAIL full_refill: got level %0d ready %b expected 4 0", sif0.level, sif0.tx_ready);
    end
    xfer_bits(40, rx);
    checks++; if (rx[39:0] !== 40'h1122334455) begin errors++; $display("FAIL full_order: got %h expected 1122334455", rx[39:0]); end
    checks++; if (sif0.level !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", sif0.level); end
    checks++; if (ucnt0 - base !== 0) begin errors++; $display("FAIL full_underrun: got %0d pulses expected 0", ucnt0 - base); end
  endtask

  task automatic test_mode3_lsb();
    logic [15:0] rx;
    int base;
    base = ucnt1;
    sif1.tx_data  = 16'h1234;
    sif1.tx_valid = 1'b1;
    tick(1);
    sif1.tx_valid = 1'b0;
    checks++; if (sif1.level !== 3'd1) begin errors++; $display("FAIL m3_level1: got %0d expected 1", sif1.level); end
    sif1.spi_csn = 1'b0;
    tick(4);
    rx = '0;
    for (int i = 0; i < 16; i++) begin
      sif1.spi_sck = 1'b0;
      tick(4);
      rx = {sif1.spi_sdo, rx[15:1]};
      sif1.spi_sck = 1'b1;
      tick(4);
    end
    sif1.spi_csn = 1'b1;
    tick(4);
    checks++; if (rx !== 16'h1234) begin errors++; $display("FAIL m3_data: got %h expected 1234", rx); end
    checks++; if (sif1.level !== 3'd0) begin errors++; $display("FAIL m3_level0: got %0d expected 0", sif1.level); end
    checks++; if (ucnt1 - base !== 0) begin errors++; $display("FAIL m3_underrun: got %0d pulses expected 0", ucnt1 - base); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rx;
    push0(8'hC3);
    sel0();
    for (int i = 0; i < 4; i++) begin
      sif0.spi_sck = 1'b1;
      tick(4);
      sif0.spi_sck = 1'b0;
      tick(4);
    end
    checks++; if (sif0.active !== 1'b1) begin errors++; $display("FAIL rm_active_before: got %b expected 1", sif0.active); end
    rst_n = 1'b0;
    #1;
    checks++; if (sif0.spi_sdo !== 1'b0) begin errors++; $display("FAIL rm_sdo: got %b expected 0", sif0.spi_sdo); end
    checks++; if (sif0.level !== 3'd0) begin errors++; $display("FAIL rm_level: got %0d expected 0", sif0.level); end
    checks++; if (sif0.tx_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", sif0.tx_ready); end
    checks++; if (sif0.active !== 1'b0) begin errors++; $display("FAIL rm_active: got %b expected 0", sif0.active); end
    sif0.spi_csn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    push0(8'h5A);
    sel0();
    xfer_bits(8, rx);
    checks++; if (rx[7:0] !== 8'h5A) begin errors++; $display("FAIL rm_data: got %h expected 5a", rx[7:0]); end
  endtask

  initial begin
    rst_n         = 1'b0;
    sif0.spi_sck  = 1'b0;
    sif0.spi_csn  = 1'b1;
    sif0.tx_data  = '0;
    sif0.tx_valid = 1'b0;
    sif1.spi_sck  = 1'b1;
    sif1.spi_csn  = 1'b1;
    sif1.tx_data  = '0;
    sif1.tx_valid = 1'b0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(4);
    test_two_words();
    test_underrun();
    test_abort();
    test_full();
    test_mode3_lsb();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
